// File: rtl/fetch_queue.sv
// Instruction fetch queue between IF and ID: circular FIFO taking 0-2 instrs/cycle, presenting up to ISSUE_W.
// Optional zero-latency fetch-to-decode path on an empty queue: define FETCHQ_BYPASS_EN.
module fetch_queue #(
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 32,
  parameter  int DEPTH   = 8,
  parameter  int ISSUE_W = 2,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                FREEZE,
  input  logic                flush,
  input  logic [1:0]          push_count,
  input  logic [DATA_W-1:0]   push_instr0,
  input  logic [DATA_W-1:0]   push_instr1,
  input  logic [ADDR_W-1:0]   push_pc0,
  output logic                push_ack,
  output logic [CW-1:0]       free_slots,
  input  logic [1:0]          pop_count,
  output logic [ISSUE_W-1:0]  out_valid,
  output logic [DATA_W-1:0]   out_instr0,
  output logic [DATA_W-1:0]   out_instr1,
  output logic [ADDR_W-1:0]   out_pc0,
  output logic [ADDR_W-1:0]   out_pc1,
  output logic [CW-1:0]       occupancy
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  entry_t     push_e [2];
  logic [1:0] push_n, pushed, popped, skip, avail, lim;
  logic       run, bypass;

  always_comb begin
    push_e[0].instr = push_instr0;
    push_e[0].pc    = push_pc0;
    push_e[1].instr = push_instr1;
    push_e[1].pc    = push_pc0 + ADDR_W'(4);
  end

  assign run        = !RESET && !flush && !FREEZE;
  assign push_n     = (push_count == 2'd3) ? 2'd0 : push_count;
  assign free_slots = CW'(DEPTH) - count_q;
  assign occupancy  = count_q;
  assign push_ack   = run && (push_n != 2'd0) && (CW'(push_n) <= free_slots);

`ifdef FETCHQ_BYPASS_EN
  assign bypass = push_ack && (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  // In bypass the slots show the offered group, so pops are bounded by it, not by storage
  always_comb begin
    lim = 2'(ISSUE_W);
    if (bypass) avail = (push_n < lim) ? push_n : lim;
    else        avail = (count_q < CW'(ISSUE_W)) ? count_q[1:0] : lim;
    popped = run ? ((pop_count < avail) ? pop_count : avail) : 2'd0;
    pushed = push_ack ? push_n : 2'd0;
    skip   = bypass ? popped : 2'd0;
  end

  // Entries consumed straight from the bypass are never written to storage
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (!FREEZE) begin
      for (int j = 0; j < 2; j++)
        if (2'(j) >= skip && 2'(j) < pushed)
          mem_d[wr_ptr_q + PW'(2'(j) - skip)] = push_e[j];
      wr_ptr_d = wr_ptr_q + PW'(pushed - skip);
      rd_ptr_d = rd_ptr_q + PW'(popped - skip);
      count_d  = count_q + CW'(pushed) - CW'(popped);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) mem_q <= mem_d;

  logic [1:0]             slot_vld;
  logic [1:0][DATA_W-1:0] slot_instr;
  logic [1:0][ADDR_W-1:0] slot_pc;

  for (genvar i = 0; i < 2; i++) begin : g_slot
    entry_t src;
    logic   vld;
    always_comb begin
      if (bypass) begin
        src = push_e[i];
        vld = (2'(i) < push_n);
      end else begin
        src = mem_q[rd_ptr_q + PW'(i)];
        vld = (CW'(i) < count_q);
      end
      if (i >= ISSUE_W) vld = 1'b0;
    end
    assign slot_vld[i]   = vld;
    assign slot_instr[i] = vld ? src.instr : '0;
    assign slot_pc[i]    = vld ? src.pc    : '0;
  end

  assign out_valid  = slot_vld[ISSUE_W-1:0];
  assign out_instr0 = slot_instr[0];
  assign out_instr1 = slot_instr[1];
  assign out_pc0    = slot_pc[0];
  assign out_pc1    = slot_pc[1];

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: ISSUE_W=2 and ISSUE_W=1 instances driven in lockstep against an ordered-list model.
module tb_fetch_queue;

  logic        CLK = 1'b0;
  logic        rst, frz, flsh;
  logic [1:0]  push_count, pop_count;
  logic [31:0] pi0, pi1, ppc;

  logic        a_ack, b_ack;
  logic [3:0]  a_occ, a_free, b_occ, b_free;
  logic [1:0]  a_valid;
  logic [0:0]  b_valid;
  logic [31:0] a_i0, a_i1, a_p0, a_p1, b_i0, b_i1, b_p0, b_p1;

  always #5 CLK = ~CLK;

  fetch_queue dut_a (
    .CLK(CLK), .RESET(rst), .FREEZE(frz), .flush(flsh),
    .push_count(push_count), .push_instr0(pi0), .push_instr1(pi1), .push_pc0(ppc),
    .push_ack(a_ack), .free_slots(a_free), .pop_count(pop_count),
    .out_valid(a_valid), .out_instr0(a_i0), .out_instr1(a_i1),
    .out_pc0(a_p0), .out_pc1(a_p1), .occupancy(a_occ));

  fetch_queue #(.ISSUE_W(1)) dut_b (
    .CLK(CLK), .RESET(rst), .FREEZE(frz), .flush(flsh),
    .push_count(push_count), .push_instr0(pi0), .push_instr1(pi1), .push_pc0(ppc),
    .push_ack(b_ack), .free_slots(b_free), .pop_count(pop_count),
    .out_valid(b_valid), .out_instr0(b_i0), .out_instr1(b_i1),
    .out_pc0(b_p0), .out_pc1(b_p1), .occupancy(b_occ));

  // Model: per instance, an in-order list (index 0 = oldest) plus its length
  int          cnt [2];
  logic [31:0] mi [2][8];
  logic [31:0] mp [2][8];
  bit          armed = 0;
  int          checks = 0, errors = 0;
  logic [31:0] next_pc = 32'h0040_0000;
  logic        last_ack;
  logic [31:0] last_i0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int iw_of(int d);  return (d == 0) ? 2 : 1; endfunction
  function automatic int pn_f();        return (push_count == 2'd3) ? 0 : int'(push_count); endfunction
  function automatic logic [31:0] pin(int k); return (k == 0) ? pi0 : pi1; endfunction
  function automatic bit ack_f(int d);
    return !rst && !flsh && !frz && pn_f() != 0 && pn_f() <= 8 - cnt[d];
  endfunction
  function automatic bit byp_f(int d);
`ifdef FETCHQ_BYPASS_EN
    return ack_f(d) && cnt[d] == 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic exp_slot(input int d, input int i, output logic v, output logic [31:0] ins, output logic [31:0] pc);
    v = 0; ins = 0; pc = 0;
    if (i < iw_of(d)) begin
      if (byp_f(d)) begin
        v = (i < pn_f());
        if (v) begin ins = pin(i); pc = ppc + 32'(4 * i); end
      end else begin
        v = (i < cnt[d]);
        if (v) begin ins = mi[d][i]; pc = mp[d][i]; end
      end
    end
  endtask

  task automatic compare();
    logic v0, v1; logic [31:0] e0, e1, q0, q1;
    exp_slot(0, 0, v0, e0, q0);
    exp_slot(0, 1, v1, e1, q1);
    chk("a_ack", a_ack, ack_f(0));
    chk("a_occ", a_occ, cnt[0]);
    chk("a_free", a_free, 8 - cnt[0]);
    chk("a_valid", a_valid, {v1, v0});
    chk("a_instr0", a_i0, e0);  chk("a_pc0", a_p0, q0);
    chk("a_instr1", a_i1, e1);  chk("a_pc1", a_p1, q1);
    exp_slot(1, 0, v0, e0, q0);
    chk("b_ack", b_ack, ack_f(1));
    chk("b_occ", b_occ, cnt[1]);
    chk("b_free", b_free, 8 - cnt[1]);
    chk("b_valid", b_valid, v0);
    chk("b_instr0", b_i0, e0);  chk("b_pc0", b_p0, q0);
    chk("b_instr1", b_i1, 0);   chk("b_pc1", b_p1, 0);
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int pn, av, pp, iw; bit ack, byp;
      if (rst || flsh) cnt[d] = 0;
      else if (!frz) begin
        iw = iw_of(d); pn = pn_f(); ack = ack_f(d); byp = byp_f(d);
        av = byp ? ((pn < iw) ? pn : iw) : ((cnt[d] < iw) ? cnt[d] : iw);
        pp = (int'(pop_count) < av) ? int'(pop_count) : av;
        if (byp) begin
          for (int k = pp; k < pn; k++) begin mi[d][k-pp] = pin(k); mp[d][k-pp] = ppc + 32'(4 * k); end
          cnt[d] = pn - pp;
        end else begin
          for (int k = 0; k < cnt[d] - pp; k++) begin mi[d][k] = mi[d][k+pp]; mp[d][k] = mp[d][k+pp]; end
          cnt[d] = cnt[d] - pp;
          if (ack) begin
            for (int k = 0; k < pn; k++) begin mi[d][cnt[d]+k] = pin(k); mp[d][cnt[d]+k] = ppc + 32'(4 * k); end
            cnt[d] = cnt[d] + pn;
          end
        end
      end
    end
    if (rst) armed = 1;
  endtask

  // One cycle: drive, compare at negedge, advance model at the active edge
  task automatic cyc(input bit r, input bit f, input bit fl, input logic [1:0] pc, input logic [1:0] popc,
                     input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] p0);
    rst = r; frz = f; flsh = fl; push_count = pc; pop_count = popc;
    pi0 = i0; pi1 = i1; ppc = p0;
    @(negedge CLK);
    last_ack = a_ack;
    last_i0  = a_i0;
    if (armed) compare();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic rcyc(input bit r, input bit f, input bit fl, input logic [1:0] pc, input logic [1:0] popc);
    cyc(r, f, fl, pc, popc, $urandom, $urandom, next_pc);
    next_pc = next_pc + 32'd8;
  endtask

  initial begin
    rcyc(1, 0, 0, 0, 0);
    rcyc(1, 1, 1, 2, 2);
    rcyc(0, 0, 0, 0, 0);
    chk("rst_occ", a_occ, 0);
    chk("rst_free", a_free, 8);
    chk("rst_valid", a_valid, 0);
    chk("rst_instr0", a_i0, 0);

    cyc(0, 0, 0, 2, 0, 32'h2008_0001, 32'h2009_0002, 32'h0040_0000);
    chk("p2_occ", a_occ, 2);
    chk("p2_valid", a_valid, 2'b11);
    chk("p2_pc1", a_p1, 32'h0040_0004);
    chk("p2_instr0", a_i0, 32'h2008_0001);

    for (int k = 0; k < 3; k++) rcyc(0, 0, 0, 2, 0);
    chk("full_occ", a_occ, 8);
    chk("full_free", a_free, 0);
    rcyc(0, 0, 0, 1, 0);
    chk("full_ack", last_ack, 0);
    chk("full_hold_occ", a_occ, 8);
    chk("full_hold_head", a_i0, 32'h2008_0001);

    rcyc(0, 0, 0, 0, 1);
    chk("seven_occ", a_occ, 7);
    rcyc(0, 0, 0, 2, 0);
    chk("seven_push2_ack", last_ack, 0);
    rcyc(0, 0, 0, 1, 0);
    chk("seven_push1_ack", last_ack, 1);
    chk("seven_push1_occ", a_occ, 8);

    rcyc(0, 0, 1, 0, 0);
    chk("flush_occ", a_occ, 0);

    rcyc(0, 0, 0, 2, 0);
    for (int k = 0; k < 20; k++) begin
      rcyc(0, 0, 0, 2, 2);
      chk("wrap_occ", a_occ, 2);
    end

    rcyc(0, 0, 1, 0, 0);
    rcyc(0, 0, 0, 2, 0);
    rcyc(0, 0, 0, 2, 0);
    rcyc(0, 0, 0, 1, 0);
    chk("five_occ", a_occ, 5);
    for (int k = 0; k < 3; k++) begin
      rcyc(0, 1, 0, 2, 2);
      chk("frz_ack", last_ack, 0);
      chk("frz_occ", a_occ, 5);
    end
    rcyc(0, 0, 1, 2, 0);
    chk("flpush_ack", last_ack, 0);
    chk("flpush_occ", a_occ, 0);
    chk("flpush_valid", a_valid, 0);
    chk("flpush_pc0", a_p0, 0);

    rcyc(0, 0, 0, 2, 0);
    rcyc(0, 0, 0, 1, 0);
    chk("iw1_start", b_occ, 3);
    rcyc(0, 0, 0, 0, 2);
    chk("iw1_pop_a", b_occ, 2);
    chk("iw2_pop_a", a_occ, 1);
    rcyc(0, 0, 0, 0, 2);
    chk("iw1_pop_b", b_occ, 1);
    rcyc(0, 0, 0, 0, 2);
    chk("iw1_pop_c", b_occ, 0);
    rcyc(0, 0, 0, 0, 2);
    chk("empty_pop", b_occ, 0);

`ifdef FETCHQ_BYPASS_EN
    cyc(0, 0, 0, 1, 1, 32'h1234_5678, 32'h0, 32'h0040_1000);
    chk("byp_ack", last_ack, 1);
    chk("byp_instr0", last_i0, 32'h1234_5678);
    chk("byp_occ", a_occ, 0);
`endif

    for (int k = 0; k < 600; k++) begin
      int x;
      x = $urandom_range(0, 99);
      rcyc(x < 2, x >= 6 && x < 16, x >= 2 && x < 6, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction fetch queue between the IF and ID stages of the pipelined MIPS core. Accepts 0–2 fetched instructions per cycle with their PCs, buffers them in a circular FIFO, and presents up to ISSUE_W instructions per cycle to decode. It supports a freeze/stall that holds all state and a taken-branch flush. It replaces the direct Instr1_fIM/Instr2_fIM → ID path, so fetch can run ahead of a stalled decode.

## Interface
- DATA_W, 32, instruction width
- ADDR_W, 32, PC width
- DEPTH, 8, queue entries; power of two, ≥4
- ISSUE_W, 2, max instructions presented and popped per cycle; 1 or 2
- CW (local), $clog2(DEPTH)+1, count width

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  synchronous, active-high reset
- FREEZE  in  1  pipeline freeze; holds all state
- flush  in  1  taken branch / redirect; empties the queue
- push_count  in  2  number of instructions offered this cycle, 0–2 (3 is illegal and treated as 0)
- push_instr0, push_instr1  in  DATA_W  offered instructions, in program order
- push_pc0  in  ADDR_W  PC of push_instr0; the PC of push_instr1 is push_pc0+4
- push_ack  out  1  combinational; the offered group is accepted this edge
- free_slots  out  CW  DEPTH − occupancy (registered state)
- pop_count  in  2  instructions consumed by ID this cycle, 0–ISSUE_W
- out_valid  out  ISSUE_W  bit i set when slot i holds a valid instruction
- out_instr0, out_instr1  out  DATA_W  head and head+1 instructions; out_instr1 exists only when ISSUE_W=2
- out_pc0, out_pc1  out  ADDR_W  PCs of the output slots
- occupancy  out  CW  entries currently held

## Operation
- Storage: circular array of {instr, pc}. Read pointer rd_ptr and write pointer wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH. A separate count register of CW bits distinguishes full from empty.
- Priority: RESET > flush > FREEZE > normal push/pop.
- Push: push_ack = !RESET && !flush && !FREEZE && push_count≠0 && push_count ≤ free_slots.
  - Acceptance is all-or-nothing. A partial group is never written.
  - free_slots is evaluated before the same-cycle pop, which is conservative.
- Pop: the effective pop is min(pop_count, occupancy, ISSUE_W). An excess pop_count is clamped, not an error. Entries leave in FIFO order.
- Simultaneous push and pop: count_next = count + pushed − popped. Both pointers advance in the same edge.
- Flush: rd_ptr = wr_ptr = count = 0 on the next edge. A push in the same cycle is discarded (push_ack=0) and the pop is ignored.
- FREEZE: pointers, count and storage are unchanged, outputs hold, and push_ack=0.
- Outputs: slot i shows entry rd_ptr+i (mod DEPTH) when i < occupancy. Otherwise out_valid[i]=0 and the slot shows instr=0 (the MIPS NOP) and pc=0.
- Storage contents are not cleared by flush. Invalid slots are masked to zero.

## Timing
- Reset values: occupancy=0, free_slots=DEPTH, out_valid=0, all out_instr/out_pc=0, push_ack=0 while RESET is high.
- Latency without bypass: an instruction pushed at edge N is visible on the outputs after edge N and can be popped at edge N+1.
- Throughput: up to 2 pushes and ISSUE_W pops per cycle, sustained. There are no bubbles at pointer wrap-around.
- Full: with count=DEPTH, push_ack=0. With count=DEPTH−1 a push of 1 is accepted and a push of 2 is rejected.
- Empty: pop is ignored and the outputs are NOPs.
- Reset mid-operation: the queue empties on the next edge regardless of FREEZE or flush. Contents already pushed are lost.

## Configuration
- FETCHQ_BYPASS_EN defined: when occupancy=0 and there is no FREEZE or flush, the offered instructions appear combinationally on the output slots with out_valid set.
  - A same-cycle pop consumes them directly, and those entries are not written.
  - Pushed entries that are not popped are written normally.
  - Zero-cycle fetch-to-decode latency.
- FETCHQ_BYPASS_EN undefined: the outputs reflect only registered storage, with the 1-cycle latency above. This is the default build.

## Test plan
- Reset, then push 2 at pc0=0x0040_0000 with instrs 0x2008_0001 and 0x2009_0002 → the next cycle shows occupancy=2, out_valid=2'b11, out_pc1=0x0040_0004.
- DEPTH=8: push 2 per cycle for 4 cycles with no pop → occupancy=8, free_slots=0. A further push gives push_ack=0 and contents are unchanged.
- Fill to 7 entries, then push_count=2 → rejected. Push_count=1 → accepted, occupancy=8.
- Push 2 and pop 2 per cycle for 20 cycles (pointers wrap more than twice) → output PCs increment by 4 with no gaps and occupancy is stable.
- Occupancy=5, assert FREEZE for 3 cycles with push and pop active → no change. Then flush together with push → occupancy=0, push_ack=0, outputs are NOPs.
- ISSUE_W=1 with pop_count=2 and occupancy=3 → exactly 1 popped per cycle. Pop at occupancy=0 → no change. With FETCHQ_BYPASS_EN defined, push 1 to the empty queue and pop 1 in the same cycle → occupancy stays 0 and out_instr0 equals push_instr0 in that cycle.
